// File: rtl/button_conditioner.sv
// button_conditioner
// Turns raw, bouncy, asynchronous push-button inputs into clean events for
// the counter and display logic. Each button gets a polarity fix, a 2-flop
// synchroniser and a debounce FSM. The FSM produces a debounced level and
// registered one-cycle press and release pulses.
// Optional feature: define AUTO_REPEAT_EN to add press auto-repeat while a
// button is held. Without the macro no repeat hardware is built.

module button_conditioner #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             CLK_50,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse
);

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1, so clog2 bits suffice.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef AUTO_REPEAT_EN
    // The repeat counter is shared between the initial delay and the period phases.
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
`else
    // The repeat settings have no effect in this build. They are folded
    // into a dead constant so that they do not trigger unused-parameter noise.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    logic [N_BTN-1:0] btn_norm;
    logic [N_BTN-1:0] sync_s1;
    logic [N_BTN-1:0] sync_s2;

    // After normalisation, 1 means pressed for every board variant.
    assign btn_norm = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

    // Two-flop synchroniser. It resets to "not pressed" so that a key held through reset reads as a new press.
    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= btn_norm;
            sync_s2 <= sync_s1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        state_t           state;
        state_t           state_next;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_next;
        logic             level_q;
        logic             level_next;
        logic             press_q;
        logic             press_next;
        logic             release_q;
        logic             release_next;
        logic             in_pressed;

        assign in_pressed = sync_s2[i];

`ifdef AUTO_REPEAT_EN
        logic [RPT_W-1:0] rpt;
        logic [RPT_W-1:0] rpt_next;
        logic             rpt_periodic;
        logic             rpt_periodic_next;
        logic [RPT_W-1:0] rpt_limit;

        // The first repeat waits REPEAT_DELAY. Every later repeat waits REPEAT_PERIOD.
        assign rpt_limit = rpt_periodic ? RPT_PERIOD_LAST : RPT_DELAY_LAST;

        // Repeat counter state. It is only cleared by reset or by the FSM decisions below.
        always_ff @(posedge CLK_50 or negedge reset_n) begin
            if (!reset_n) begin
                rpt          <= '0;
                rpt_periodic <= 1'b0;
            end else begin
                rpt          <= rpt_next;
                rpt_periodic <= rpt_periodic_next;
            end
        end
`endif

        // Debounce FSM state, counter and registered outputs.
        always_ff @(posedge CLK_50 or negedge reset_n) begin
            if (!reset_n) begin
                state     <= RELEASED;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state     <= state_next;
                cnt       <= cnt_next;
                level_q   <= level_next;
                press_q   <= press_next;
                release_q <= release_next;
            end
        end

        // Next-state logic. A level change is accepted only after s2 holds steady through a full debounce count.
        always_comb begin
            state_next   = state;
            cnt_next     = cnt;
            level_next   = level_q;
            press_next   = 1'b0;
            release_next = 1'b0;
`ifdef AUTO_REPEAT_EN
            rpt_next          = rpt;
            rpt_periodic_next = rpt_periodic;
`endif
            case (state)
                RELEASED: begin
`ifdef AUTO_REPEAT_EN
                    rpt_next          = '0;
                    rpt_periodic_next = 1'b0;
`endif
                    if (in_pressed) begin
                        state_next = PRESS_CHK;
                        cnt_next   = '0;
                    end
                end

                PRESS_CHK: begin
                    if (!in_pressed) begin
                        state_next = RELEASED;
                    end else if (cnt == CNT_LAST) begin
                        state_next = PRESSED;
                        press_next = 1'b1;
                        level_next = 1'b1;
`ifdef AUTO_REPEAT_EN
                        rpt_next          = '0;
                        rpt_periodic_next = 1'b0;
`endif
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end

                PRESSED: begin
                    if (!in_pressed) begin
                        state_next = RELEASE_CHK;
                        cnt_next   = '0;
                    end else begin
`ifdef AUTO_REPEAT_EN
                        if (rpt == rpt_limit) begin
                            press_next        = 1'b1;
                            rpt_next          = '0;
                            rpt_periodic_next = 1'b1;
                        end else begin
                            rpt_next = rpt + 1'b1;
                        end
`endif
                    end
                end

                RELEASE_CHK: begin
                    // The repeat counter stays frozen here. A bounce back to PRESSED resumes it.
                    if (in_pressed) begin
                        state_next = PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state_next   = RELEASED;
                        release_next = 1'b1;
                        level_next   = 1'b0;
`ifdef AUTO_REPEAT_EN
                        rpt_next          = '0;
                        rpt_periodic_next = 1'b0;
`endif
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end

                default: begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                    level_next = 1'b0;
                end
            endcase
        end

        assign btn_level[i]     = level_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
// Directed test of button_conditioner with DEBOUNCE_CYCLES = 4, active-low keys,
// REPEAT_DELAY = 10 and REPEAT_PERIOD = 5. Inputs change on the falling
// edge. Window index k means the sample taken after rising edge k, where
// edge 0 is the first edge that sees the new raw value.

module tb_button_conditioner;

    localparam int N_BTN = 2;
    localparam int MAXP  = 8;

    logic             CLK_50 = 1'b0;
    logic             reset_n;
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;

    always #5 CLK_50 = ~CLK_50;

    button_conditioner #(
        .N_BTN(N_BTN),
        .DEBOUNCE_CYCLES(4),
        .BTN_ACTIVE_LOW(1),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(5)
    ) dut (
        .CLK_50(CLK_50),
        .reset_n(reset_n),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse)
    );

    int checks = 0;
    int errors = 0;
    int both_total = 0;
    int bounce_rel = 0;
    int bounce_prs = 0;
    int press_cnt[N_BTN];
    int release_cnt[N_BTN];
    int press_edge[N_BTN][MAXP];
    int release_edge[N_BTN];
    int level_edge[N_BTN];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, $signed(actual), $signed(expected));
        end
    endtask

    task automatic applyStimulus(input logic [N_BTN-1:0] raw);
        btn_raw = raw;
    endtask

    // Step n cycles and record pulse positions and the first level change for each bit.
    task automatic runWindow(input int n);
        logic [N_BTN-1:0] start_level;
        start_level = btn_level;
        for (int b = 0; b < N_BTN; b++) begin
            press_cnt[b]    = 0;
            release_cnt[b]  = 0;
            release_edge[b] = -1;
            level_edge[b]   = -1;
            for (int k = 0; k < MAXP; k++) press_edge[b][k] = -1;
        end
        for (int e = 0; e < n; e++) begin
            @(negedge CLK_50);
            for (int b = 0; b < N_BTN; b++) begin
                if (press_pulse[b] === 1'b1) begin
                    if (press_cnt[b] < MAXP) press_edge[b][press_cnt[b]] = e;
                    press_cnt[b]++;
                end
                if (release_pulse[b] === 1'b1) begin
                    if (release_cnt[b] == 0) release_edge[b] = e;
                    release_cnt[b]++;
                end
                if (press_pulse[b] === 1'b1 && release_pulse[b] === 1'b1) both_total++;
                if (level_edge[b] < 0 && btn_level[b] !== start_level[b]) level_edge[b] = e;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(2'b11);
        repeat (2) @(negedge CLK_50);
        checkOutput("reset_level", btn_level, 2'b00);
        checkOutput("reset_press", press_pulse, 2'b00);
        checkOutput("reset_release", release_pulse, 2'b00);
        reset_n = 1'b1;
        runWindow(5);
        checkOutput("idle_press0", press_cnt[0], 0);
        checkOutput("idle_press1", press_cnt[1], 0);

        // Basic press on bit 0
        applyStimulus(2'b10);
        runWindow(10);
        checkOutput("press0_count", press_cnt[0], 1);
        checkOutput("press0_edge", press_edge[0][0], 6);
        checkOutput("press0_level_edge", level_edge[0], 6);
        checkOutput("press0_other_bit", press_cnt[1], 0);
        checkOutput("press0_level", btn_level, 2'b01);

        // Clean release of bit 0
        applyStimulus(2'b11);
        runWindow(10);
        checkOutput("rel0_count", release_cnt[0], 1);
        checkOutput("rel0_edge", release_edge[0], 6);
        checkOutput("rel0_level", btn_level, 2'b00);

        // Short glitch: low for 3 cycles only
        applyStimulus(2'b10);
        runWindow(3);
        checkOutput("glitch_press_a", press_cnt[0], 0);
        applyStimulus(2'b11);
        runWindow(10);
        checkOutput("glitch_press_b", press_cnt[0], 0);
        checkOutput("glitch_level_edge", level_edge[0], -1);
        checkOutput("glitch_level", btn_level, 2'b00);

        // Press, then bouncy release
        applyStimulus(2'b10);
        runWindow(10);
        checkOutput("bounce_press", press_cnt[0], 1);
        applyStimulus(2'b11); runWindow(1);
        bounce_rel += release_cnt[0]; bounce_prs += press_cnt[0];
        applyStimulus(2'b10); runWindow(1);
        bounce_rel += release_cnt[0]; bounce_prs += press_cnt[0];
        applyStimulus(2'b11); runWindow(1);
        bounce_rel += release_cnt[0]; bounce_prs += press_cnt[0];
        applyStimulus(2'b10); runWindow(1);
        bounce_rel += release_cnt[0]; bounce_prs += press_cnt[0];
        applyStimulus(2'b11); runWindow(10);
        bounce_prs += press_cnt[0];
        checkOutput("bounce_early_release", bounce_rel, 0);
        checkOutput("bounce_spurious_press", bounce_prs, 0);
        checkOutput("bounce_rel_count", release_cnt[0], 1);
        checkOutput("bounce_rel_edge", release_edge[0], 6);

        // Both buttons pressed on the same edge, then released together
        applyStimulus(2'b00);
        runWindow(10);
        checkOutput("dual_press0_edge", press_edge[0][0], 6);
        checkOutput("dual_press1_edge", press_edge[1][0], 6);
        checkOutput("dual_press_counts", press_cnt[0] + press_cnt[1], 2);
        applyStimulus(2'b11);
        runWindow(10);
        checkOutput("dual_rel0_edge", release_edge[0], 6);
        checkOutput("dual_rel1_edge", release_edge[1], 6);

        // Reset while bit 1 is pressed and bit 0 is in its press check
        applyStimulus(2'b01);
        runWindow(10);
        checkOutput("pre_reset_press1", press_edge[1][0], 6);
        applyStimulus(2'b00);
        runWindow(4);
        checkOutput("pre_reset_level", btn_level, 2'b10);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("mid_reset_level", btn_level, 2'b00);
        checkOutput("mid_reset_press", press_pulse, 2'b00);
        checkOutput("mid_reset_release", release_pulse, 2'b00);
        repeat (2) @(negedge CLK_50);
        reset_n = 1'b1;
        runWindow(10);
        checkOutput("post_reset_press0_cnt", press_cnt[0], 1);
        checkOutput("post_reset_press0_edge", press_edge[0][0], 6);
        checkOutput("post_reset_press1_cnt", press_cnt[1], 1);
        checkOutput("post_reset_press1_edge", press_edge[1][0], 6);
        applyStimulus(2'b11);
        runWindow(10);
        checkOutput("post_reset_rel0_edge", release_edge[0], 6);

        // Long hold on bit 0 (auto-repeat when enabled)
        applyStimulus(2'b10);
        runWindow(33);
`ifdef AUTO_REPEAT_EN
        checkOutput("hold_press_count", press_cnt[0], 5);
        checkOutput("hold_edge_a", press_edge[0][0], 6);
        checkOutput("hold_edge_b", press_edge[0][1], 16);
        checkOutput("hold_edge_c", press_edge[0][2], 21);
        checkOutput("hold_edge_d", press_edge[0][3], 26);
        checkOutput("hold_edge_e", press_edge[0][4], 31);
`else
        checkOutput("hold_press_count", press_cnt[0], 1);
        checkOutput("hold_edge_a", press_edge[0][0], 6);
`endif
        checkOutput("hold_no_release", release_cnt[0], 0);
        applyStimulus(2'b11);
        runWindow(12);
        checkOutput("hold_rel_press", press_cnt[0], 0);
        checkOutput("hold_rel_edge", release_edge[0], 6);
        checkOutput("hold_rel_count", release_cnt[0], 1);

        checkOutput("never_both_pulses", both_total, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
